// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: opcode constants, FSM state encoding and opcode classification
// shared by the RAM arbiter and its testbench.
package ram_arb_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    function automatic logic is_opener(input logic [1:0] op);
        return op == OP_WR_ADDR || op == OP_RD_ADDR;
    endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: 2-way round-robin picker; on a tie the requester not granted last wins.
module ram_arb_rr (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant
);

    assign grant = (valid0 && valid1) ? ~last_grant : valid1;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two requesters share one RAM command port; an opener locks the RAM
// to its requester until a closer, a read return or an idle timeout releases it.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] req0_din,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    output logic [ADDR_SIZE-1:0] req0_dout,
    output logic                 req0_tx_valid,
    input  logic [ADDR_SIZE+1:0] req1_din,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    output logic [ADDR_SIZE-1:0] req1_dout,
    output logic                 req1_tx_valid,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 timeout,
    output logic                 protocol_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t               state_q;
    logic                 owner_q, last_q;
    logic [CW-1:0]        cnt_q;
    logic [ADDR_SIZE+1:0] ram_din_q;
    logic                 ram_rx_valid_q;
    logic [ADDR_SIZE-1:0] dout0_q, dout1_q;
    logic                 tx0_q, tx1_q, timeout_q, perr_q;

    logic                 grant, sel, vld, acc, fwd, stall;
    logic [ADDR_SIZE+1:0] word;
    logic [1:0]           op;

    ram_arb_rr u_rr (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    // In IDLE the round-robin winner is served; otherwise only the lock owner.
    always_comb begin
        sel   = (state_q == ST_IDLE) ? grant : owner_q;
        vld   = sel ? req1_valid : req0_valid;
        word  = sel ? req1_din : req0_din;
        op    = word[ADDR_SIZE+1:ADDR_SIZE];
        acc   = vld && state_q != ST_WAIT_RD;
        fwd   = acc && (state_q == ST_LOCKED || is_opener(op));
        stall = (state_q == ST_LOCKED && !vld) || (state_q == ST_WAIT_RD && !ram_tx_valid);
    end

    assign req0_ready    = state_q != ST_WAIT_RD && !sel;
    assign req1_ready    = state_q != ST_WAIT_RD && sel;
    assign ram_din       = ram_din_q;
    assign ram_rx_valid  = ram_rx_valid_q;
    assign req0_dout     = dout0_q;
    assign req1_dout     = dout1_q;
    assign req0_tx_valid = tx0_q;
    assign req1_tx_valid = tx1_q;
    assign timeout       = timeout_q;
    assign protocol_err  = perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            last_q         <= 1'b1;
            cnt_q          <= '0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
            dout0_q        <= '0;
            dout1_q        <= '0;
            tx0_q          <= 1'b0;
            tx1_q          <= 1'b0;
            timeout_q      <= 1'b0;
            perr_q         <= 1'b0;
        end else begin
            ram_rx_valid_q <= fwd;
            tx0_q          <= 1'b0;
            tx1_q          <= 1'b0;
            timeout_q      <= 1'b0;
            perr_q         <= 1'b0;
            if (fwd)
                ram_din_q <= word;
            case (state_q)
                ST_IDLE: begin
                    cnt_q  <= '0;
                    perr_q <= acc && !is_opener(op);
                    if (fwd) begin
                        state_q <= ST_LOCKED;
                        owner_q <= sel;
                        last_q  <= sel;
                    end
                end
                ST_LOCKED: if (acc) begin
                    cnt_q   <= '0;
                    state_q <= op == OP_WR_DATA ? ST_IDLE : op == OP_RD_DATA ? ST_WAIT_RD : ST_LOCKED;
                end
                ST_WAIT_RD: if (ram_tx_valid) begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                    if (owner_q) begin
                        dout1_q <= ram_dout;
                        tx1_q   <= 1'b1;
                    end else begin
                        dout0_q <= ram_dout;
                        tx0_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // The TIMEOUT-th consecutive idle cycle abandons the transaction.
            if (stall) begin
                if (cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_q <= 1'b1;
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus random traffic, each cycle checked
// against a transaction-level model of lock ownership, reads and timeouts.
module tb_ram_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] req0_din = '0, req1_din = '0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready, req0_tx_valid, req1_tx_valid;
    logic [7:0] req0_dout, req1_dout;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = '0;
    logic       ram_tx_valid = 1'b0;
    logic       timeout, protocol_err;

    int errors = 0, checks = 0, to_seen = 0;

    int         m_lock;
    bit         m_rdw, m_last;
    int         m_idle;
    logic [7:0] m_dout[2];
    bit         e_rxv, e_to, e_pe;
    bit         e_tx[2];
    logic [9:0] e_din;

    ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_din(req0_din), .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dout(req0_dout), .req0_tx_valid(req0_tx_valid),
        .req1_din(req1_din), .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dout(req1_dout), .req1_tx_valid(req1_tx_valid),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
        .timeout(timeout), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_lock = -1; m_rdw = 0; m_idle = 0; m_last = 1;
        m_dout = '{8'h00, 8'h00};
    endtask

    task automatic idle_tick();
        m_idle++;
        if (m_idle == TIMEOUT) begin
            e_to = 1; m_lock = -1; m_rdw = 0; m_idle = 0;
        end
    endtask

    // Called at a falling edge with inputs already applied; spans one rising edge.
    task automatic step();
        bit         v[2];
        logic [9:0] d[2];
        bit         r[2];
        int         win;
        v = '{req0_valid, req1_valid};
        d = '{req0_din, req1_din};
        #1;
        r = '{0, 0};
        win = (v[0] && v[1]) ? int'(!m_last) : (v[1] ? 1 : 0);
        if (!m_rdw) r[m_lock >= 0 ? m_lock : win] = 1;
        chk("req0_ready", req0_ready, r[0]);
        chk("req1_ready", req1_ready, r[1]);
        e_rxv = 0; e_tx = '{0, 0}; e_to = 0; e_pe = 0;
        if (m_rdw) begin
            if (ram_tx_valid) begin
                m_dout[m_lock] = ram_dout; e_tx[m_lock] = 1;
                m_lock = -1; m_rdw = 0; m_idle = 0;
            end else idle_tick();
        end else if (m_lock >= 0) begin
            if (v[m_lock]) begin
                e_rxv = 1; e_din = d[m_lock]; m_idle = 0;
                if (d[m_lock][9:8] == 2'b01) m_lock = -1;
                else if (d[m_lock][9:8] == 2'b11) m_rdw = 1;
            end else idle_tick();
        end else if (v[win]) begin
            if (d[win][8] == 1'b0) begin
                e_rxv = 1; e_din = d[win]; m_lock = win; m_last = win[0]; m_idle = 0;
            end else e_pe = 1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("ram_rx_valid", ram_rx_valid, e_rxv);
        if (e_rxv) chk("ram_din", ram_din, e_din);
        chk("req0_tx_valid", req0_tx_valid, e_tx[0]);
        chk("req1_tx_valid", req1_tx_valid, e_tx[1]);
        chk("req0_dout", req0_dout, m_dout[0]);
        chk("req1_dout", req1_dout, m_dout[1]);
        chk("timeout", timeout, e_to);
        chk("protocol_err", protocol_err, e_pe);
        to_seen += int'(timeout);
    endtask

    task automatic drive(input bit v0, input logic [9:0] d0, input bit v1, input logic [9:0] d1,
                         input bit tv, input logic [7:0] td);
        req0_valid = v0; req0_din = d0; req1_valid = v1; req1_din = d1;
        ram_tx_valid = tv; ram_dout = td;
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_rx_valid"}, ram_rx_valid, 0);
        chk({tag, "_ram_din"}, ram_din, 0);
        chk({tag, "_req0_dout"}, req0_dout, 0);
        chk({tag, "_req1_dout"}, req1_dout, 0);
        chk({tag, "_req0_tx_valid"}, req0_tx_valid, 0);
        chk({tag, "_req1_tx_valid"}, req1_tx_valid, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_protocol_err"}, protocol_err, 0);
    endtask

    initial begin
        int pv;
        m_reset();
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Tie after reset goes to req0; the next tie goes to req1.
        drive(1, 10'h001, 1, 10'h002, 0, 0);
        drive(1, 10'h1AA, 1, 10'h002, 0, 0);
        drive(1, 10'h001, 1, 10'h002, 0, 0);
        drive(1, 10'h001, 1, 10'h133, 0, 0);

        // Write pair from req0 while req1 waits.
        drive(1, 10'h0FF, 1, 10'h001, 0, 0);
        drive(1, 10'h15C, 1, 10'h001, 0, 0);
        drive(0, 10'h000, 0, 10'h000, 1, 8'hEE);

        // Read from req1 with a delayed RAM return.
        drive(0, 10'h000, 1, 10'h2FF, 0, 0);
        drive(0, 10'h000, 1, 10'h300, 0, 0);
        drive(0, 10'h000, 0, 10'h000, 0, 0);
        drive(0, 10'h000, 0, 10'h000, 1, 8'h5C);
        chk("read_return_req1_dout", req1_dout, 8'h5C);
        drive(0, 10'h000, 0, 10'h000, 0, 0);

        // Owner goes silent; req1 is granted only after the timeout.
        to_seen = 0;
        drive(1, 10'h003, 0, 10'h000, 0, 0);
        for (int i = 0; i < TIMEOUT + 1; i++) drive(0, 10'h000, 1, 10'h004, 0, 0);
        chk("timeout_pulses", to_seen, 1);
        drive(0, 10'h000, 1, 10'h104, 0, 0);

        // Closer while idle is discarded with a protocol error.
        drive(1, 10'h3AB, 0, 10'h000, 0, 0);
        drive(0, 10'h000, 0, 10'h000, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            pv = ((i / 500) % 2) != 0 ? 8 : 70;
            req0_valid   = $urandom_range(0, 99) < pv;
            req1_valid   = $urandom_range(0, 99) < pv;
            req0_din     = 10'($urandom);
            req1_din     = 10'($urandom);
            ram_tx_valid = $urandom_range(0, 3) == 0;
            ram_dout     = 8'($urandom);
            step();
        end

        // Reset in the middle of a read abandons it.
        drive(1, 10'h2AB, 0, 10'h000, 0, 0);
        drive(1, 10'h300, 0, 10'h000, 0, 0);
        drive(0, 10'h000, 0, 10'h000, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk);
        @(negedge clk);
        m_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(0, 10'h000, 0, 10'h000, 1, 8'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, giving the RAM address/data width (command word = ADDR_SIZE+2 bits).
REQ-002 SHALL have parameter TIMEOUT, default 16, giving the maximum idle cycles tolerated inside a locked transaction.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_din / req1_din  input  10  command word: [9:8] opcode, [7:0] address or data.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1  command word present.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  word accepted this cycle when valid && ready.
REQ-008 SHALL have ports req0_dout / req1_dout  output  8  read data returned to that requester.
REQ-009 SHALL have ports req0_tx_valid / req1_tx_valid  output  1  one-cycle pulse qualifying reqN_dout.
REQ-010 SHALL have ports ram_din  output  10 and ram_rx_valid  output  1  command to the RAM.
REQ-011 SHALL have ports ram_dout  input  8 and ram_tx_valid  input  1  read return from the RAM.
REQ-012 SHALL have ports timeout  output  1 and protocol_err  output  1  one-cycle status pulses.

Function
REQ-013 SHALL classify opcodes 00 (write addr) and 10 (read addr) as openers, and 01 (write data) and 11 (read data) as closers.
REQ-014 SHALL implement FSM IDLE, LOCKED and WAIT_RD, with an owner bit.
- IDLE: accepts an opener; the owner is the arbitration winner.
- LOCKED: accepts owner words only.
- WAIT_RD: accepts nothing.
REQ-015 SHALL arbitrate round-robin in IDLE: if both requesters are valid, the one not granted last wins; otherwise the sole valid requester wins.
REQ-016 SHALL assert ready combinationally:
- IDLE: to the winner only.
- LOCKED: to the owner only.
- WAIT_RD: to neither requester.
REQ-017 SHALL forward each accepted non-discarded word as ram_din with ram_rx_valid=1 on the next cycle (one-cycle latency); ram_rx_valid=0 otherwise.
REQ-018 SHALL move from IDLE to LOCKED on an accepted opener.
REQ-019 SHALL, in LOCKED, on an accepted owner word:
- 01: forward it and go to IDLE.
- 11: forward it and go to WAIT_RD.
- Opener: forward it and remain LOCKED (address overwrite).
REQ-020 SHALL, in IDLE, accept and discard a closer word (no ram_rx_valid), pulse protocol_err, and leave the grant history unchanged.
REQ-021 SHALL, in WAIT_RD on ram_tx_valid=1, register ram_dout into the owner's dout, pulse the owner's tx_valid the following cycle, and go to IDLE.
REQ-022 SHALL hold reqN_dout until the next read return to that requester.
REQ-023 SHALL count consecutive cycles in LOCKED without owner valid, and in WAIT_RD without ram_tx_valid. The count resets on entering a state or on a handshake.
REQ-024 SHALL, when the count reaches TIMEOUT, pulse timeout, return to IDLE, and issue no RAM command.
REQ-025 SHALL ignore ram_tx_valid outside WAIT_RD.
REQ-026 SHALL update the round-robin pointer only when an opener is accepted in IDLE.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force the following, and hold them until rst_n is high:
- State IDLE, timeout counter 0.
- Last-grant pointer = 1, so req0 wins the first tie.
- ram_din=0, ram_rx_valid=0.
- req0_dout=0, req1_dout=0, req0_tx_valid=0, req1_tx_valid=0.
- timeout=0, protocol_err=0.
REQ-028 SHALL abandon any in-flight transaction on reset; no RAM command is issued for it.

Structure
REQ-029 SHALL place opcode constants (OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA) and the FSM state encoding in shared package ram_arb_pkg.
REQ-030 SHALL instantiate one sub-module, ram_arb_rr, a 2-way round-robin picker with inputs valid0, valid1 and last_grant, and output grant.

Verification
REQ-031 SHALL drive req0 with 00_1111_1111 then 01_0101_1100 -> ram_din shows the same two words on consecutive forwarding cycles, and req1_ready=0 throughout.
REQ-032 SHALL drive both requesters valid in IDLE with 00_0000_0001 / 00_0000_0010 -> req0 is served first (both pairs complete); on a repeated tie, req1 is served first.
REQ-033 SHALL drive req1 with 10_1111_1111 then 11_0000_0000, with the RAM model returning 0x5C -> req1_dout=0x5C with a 1-cycle req1_tx_valid pulse, and req0_tx_valid stays 0.
REQ-034 SHALL drive req0 with 00_0000_0011 then drop valid for 16 cycles -> timeout pulses once, the FSM returns to IDLE, and a pending req1 is then granted.
REQ-035 SHALL drive req0 with 11_1010_1011 in IDLE -> ready=1, protocol_err pulses, and ram_rx_valid stays 0.
REQ-036 SHALL assert rst_n low while in WAIT_RD -> all outputs go to 0 immediately, and no tx_valid pulse follows release.
